control_word_sequencer: RTL and testbench

Sequences the 55-bit datapath control words through the `top` datapath. Replaces file-fed stimulus with an on-chip program store. Software or a host loads up to DEPTH control words, then issues `start`. The block replays words 0..`last_addr` for `loop_cnt`+1 iterations and drives one word per accepted cycle onto the datapath's `ControlWord` input. It sits directly upstream of `top`, with a valid/ready handshake so the datapath can stall it.

---
 rtl/cw_seq_pkg.sv | 28 ++
 rtl/cw_program_ram.sv | 33 +++
 rtl/control_word_sequencer.sv | 136 +++++++++++++
 tb/tb_control_word_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_seq_pkg.sv
// ============================================================================
// cw_seq_pkg : shared types and constants for the control word sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cw_seq_pkg;

    localparam int CW_WIDTH = 55;
    localparam logic [CW_WIDTH-1:0] CW_NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cw_seq_state_t;

    // Source of the next registered control word
    typedef enum logic [1:0] {
        CW_SRC_NOP   = 2'd0,
        CW_SRC_HOLD  = 2'd1,
        CW_SRC_FETCH = 2'd2,
        CW_SRC_START = 2'd3
    } cw_src_t;

endpackage

`default_nettype wire

// File: rtl/cw_program_ram.sv
// ============================================================================
// cw_program_ram : DEPTH x CW_WIDTH program store, sync write / async read
// Rev 1.0
// ============================================================================
`default_nettype none

module cw_program_ram
    import cw_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CW_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CW_WIDTH-1:0] rd_data
);

    logic [CW_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/control_word_sequencer.sv
// ============================================================================
// control_word_sequencer : replays a stored control-word program into the datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module control_word_sequencer
    import cw_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int LOOP_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [CW_WIDTH-1:0] prog_data,
    output logic                prog_err,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   last_addr,
    input  logic [LOOP_W-1:0]   loop_cnt,
    output logic [CW_WIDTH-1:0] control_word,
    output logic                cw_valid,
    input  logic                dp_ready,
    output logic                busy,
    output logic                done
);

    cw_seq_state_t       state, state_next;
    logic [ADDR_W-1:0]   pc, pc_next;
    logic [ADDR_W-1:0]   last_q, last_next;
    logic [LOOP_W-1:0]   remaining, remaining_next;
    cw_src_t             cw_src;
    logic [CW_WIDTH-1:0] cw_next;
    logic [CW_WIDTH-1:0] rd_data;
    logic                ram_we;

    assign ram_we = prog_we && (state == IDLE);

    // Read port addresses the next pc so the word is ready at the same edge
    cw_program_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc_next),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            last_q       <= '0;
            remaining    <= '0;
            control_word <= CW_NOP;
            prog_err     <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            last_q       <= last_next;
            remaining    <= remaining_next;
            control_word <= cw_next;
            prog_err     <= prog_we && (state != IDLE);
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        last_next      = last_q;
        remaining_next = remaining;
        cw_src         = CW_SRC_NOP;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next     = RUN;
                    pc_next        = '0;
                    last_next      = last_addr;
                    remaining_next = loop_cnt;
                    cw_src         = CW_SRC_START;
                end
            end
            RUN: begin
                cw_src = CW_SRC_HOLD;
                if (abort) begin
                    state_next = IDLE;
                    pc_next    = '0;
                    cw_src     = CW_SRC_NOP;
                end else if (dp_ready) begin
                    if (pc < last_q) begin
                        pc_next = pc + ADDR_W'(1);
                        cw_src  = CW_SRC_FETCH;
                    end else if (remaining != '0) begin
                        pc_next        = '0;
                        remaining_next = remaining - LOOP_W'(1);
                        cw_src         = CW_SRC_FETCH;
                    end else begin
                        state_next = DONE;
                        pc_next    = '0;
                        cw_src     = CW_SRC_NOP;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A write to word 0 in the start cycle lands at the same edge, so forward it
    always_comb begin
        cw_next = CW_NOP;
        unique case (cw_src)
            CW_SRC_HOLD:  cw_next = control_word;
            CW_SRC_FETCH: cw_next = rd_data;
            CW_SRC_START: cw_next = (prog_we && (prog_addr == '0)) ? prog_data : rd_data;
            default:      cw_next = CW_NOP;
        endcase
    end

    assign cw_valid = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_control_word_sequencer.sv
// ============================================================================
// tb_control_word_sequencer : directed self-checking bench for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_control_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [54:0] prog_data;
    logic        prog_err;
    logic        start;
    logic        abort;
    logic [3:0]  last_addr;
    logic [7:0]  loop_cnt;
    logic [54:0] control_word;
    logic        cw_valid;
    logic        dp_ready;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    control_word_sequencer #(.DEPTH(16), .ADDR_W(4), .LOOP_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_err     (prog_err),
        .start        (start),
        .abort        (abort),
        .last_addr    (last_addr),
        .loop_cnt     (loop_cnt),
        .control_word (control_word),
        .cw_valid     (cw_valid),
        .dp_ready     (dp_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic prog(input logic [3:0] a, input logic [54:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic load_base();
        prog(4'd0, 55'h1);
        prog(4'd1, 55'h2);
        prog(4'd2, 55'h4);
        prog(4'd3, 55'h8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++;
        if ({control_word, cw_valid, busy, done, prog_err} !== 59'd0) begin
            bad++;
            $display("FAIL reset: cw=%h valid=%b busy=%b done=%b err=%b, want all 0",
                     control_word, cw_valid, busy, done, prog_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_run();
        load_base();
        last_addr = 4'd3; loop_cnt = 8'd0; dp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (control_word !== (55'h1 << i) || cw_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL basic_word%0d: cw=%h valid=%b busy=%b done=%b, want cw=%h valid=1 busy=1 done=0",
                         i, control_word, cw_valid, busy, done, 55'h1 << i);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || cw_valid !== 1'b0 || control_word !== 55'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b valid=%b cw=%h busy=%b, want done=1 valid=0 cw=0 busy=0",
                     done, cw_valid, control_word, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_loop_stall();
        int k = 0;
        int stalls = 0;
        int cycles = 0;
        logic [54:0] exp;
        last_addr = 4'd3; loop_cnt = 8'd2; dp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (k < 12 && cycles < 40) begin
            exp = 55'h1 << (k % 4);
            total++;
            if (control_word !== exp || cw_valid !== 1'b1) begin
                bad++;
                $display("FAIL loop_word%0d: cw=%h valid=%b, want cw=%h valid=1", k, control_word, cw_valid, exp);
            end
            if (k == 2 && stalls < 3) begin
                dp_ready = 1'b0;
                stalls++;
            end else begin
                dp_ready = 1'b1;
                k++;
            end
            tick();
            cycles++;
        end
        dp_ready = 1'b1;
        total++;
        if (k != 12 || done !== 1'b1 || cw_valid !== 1'b0) begin
            bad++;
            $display("FAIL loop_done: transfers=%0d done=%b valid=%b, want 12 1 0", k, done, cw_valid);
        end
        tick();
    endtask

    task automatic test_single_word();
        int n = 0;
        int cycles = 0;
        prog(4'd0, 55'h7FFFFFFFFFFFFF);
        last_addr = 4'd0; loop_cnt = 8'd4; dp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (cw_valid === 1'b1 && cycles < 20) begin
            total++;
            if (control_word !== 55'h7FFFFFFFFFFFFF) begin
                bad++;
                $display("FAIL single_word%0d: cw=%h want 7fffffffffffff", n, control_word);
            end
            n++;
            tick();
            cycles++;
        end
        total++;
        if (n != 5 || done !== 1'b1) begin
            bad++;
            $display("FAIL single_count: transfers=%0d done=%b, want 5 1", n, done);
        end
        tick();
    endtask

    task automatic test_abort();
        int cycles = 0;
        load_base();
        last_addr = 4'd3; loop_cnt = 8'd0; dp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (control_word !== 55'h4) begin
            bad++;
            $display("FAIL abort_pre: cw=%h want 4", control_word);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (cw_valid !== 1'b0 || control_word !== 55'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_stop: valid=%b cw=%h busy=%b done=%b, want 0 0 0 0",
                     cw_valid, control_word, busy, done);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL abort_nodone: done=%b want 0", done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (control_word !== 55'h1 || cw_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: cw=%h valid=%b, want 1 1", control_word, cw_valid);
        end
        while (done !== 1'b1 && cycles < 10) begin
            tick();
            cycles++;
        end
        total++;
        if (cycles != 4) begin
            bad++;
            $display("FAIL abort_rerun: cycles to done=%0d want 4", cycles);
        end
        tick();
    endtask

    task automatic test_prog_err();
        logic [54:0] seen [4];
        last_addr = 4'd3; loop_cnt = 8'd0; dp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 55'h55;
        tick();
        prog_we = 1'b0;
        total++;
        if (prog_err !== 1'b1) begin
            bad++;
            $display("FAIL prog_err_pulse: err=%b want 1", prog_err);
        end
        tick();
        total++;
        if (prog_err !== 1'b0) begin
            bad++;
            $display("FAIL prog_err_clear: err=%b want 0", prog_err);
        end
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen[i] = control_word;
            tick();
        end
        total++;
        if (seen[2] !== 55'h4) begin
            bad++;
            $display("FAIL prog_err_keep: mem2=%h want 4", seen[2]);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if ({control_word, cw_valid, busy, done, prog_err} !== 59'd0) begin
            bad++;
            $display("FAIL midreset: cw=%h valid=%b busy=%b done=%b err=%b, want all 0",
                     control_word, cw_valid, busy, done, prog_err);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: done=%b busy=%b want 0 0", done, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (control_word !== (55'h1 << i)) begin
                bad++;
                $display("FAIL midreset_word%0d: cw=%h want %h", i, control_word, 55'h1 << i);
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL midreset_done: done=%b want 1", done);
        end
        tick();
    endtask

    task automatic test_start_write();
        last_addr = 4'd0; loop_cnt = 8'd0; start = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 55'h123;
        tick();
        start = 1'b0; prog_we = 1'b0;
        total++;
        if (control_word !== 55'h123 || cw_valid !== 1'b1 || prog_err !== 1'b0) begin
            bad++;
            $display("FAIL start_write: cw=%h valid=%b err=%b, want 123 1 0", control_word, cw_valid, prog_err);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL start_write_done: done=%b want 1", done);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; abort = 1'b0; last_addr = '0; loop_cnt = '0; dp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_loop_stall();
        test_single_word();
        test_abort();
        test_prog_err();
        test_mid_reset();
        test_start_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
